// File: rtl/dmem_pkg.sv
// dmem_pkg: MMIO offsets, console status bit positions and register decode shared by the data responder
package dmem_pkg;

    localparam logic [63:0] MTIME        = 64'h00;
    localparam logic [63:0] MTIMECMP     = 64'h08;
    localparam logic [63:0] CONSOLE_TX   = 64'h10;
    localparam logic [63:0] CONSOLE_CTRL = 64'h18;

    localparam int EMPTY     = 0;
    localparam int FULL      = 1;
    localparam int OVF       = 2;
    localparam int COUNT_LSB = 8;
    localparam int CLR_OVF   = 2;

    typedef enum logic [2:0] {
        SEL_RAM,
        SEL_MTIME,
        SEL_MTIMECMP,
        SEL_TX,
        SEL_CTRL,
        SEL_NONE
    } sel_e;

    function automatic sel_e mmio_sel(input logic [63:0] off);
        logic [63:0] a;
        a = off & ~64'h7;
        return a == MTIME        ? SEL_MTIME    :
               a == MTIMECMP     ? SEL_MTIMECMP :
               a == CONSOLE_TX   ? SEL_TX       :
               a == CONSOLE_CTRL ? SEL_CTRL     : SEL_NONE;
    endfunction

endpackage

// File: rtl/console_fifo.sv
// console_fifo: synchronous FIFO for console transmit bytes
//   clk, rst (sync, active-low) | push/din/accept: write side, accept = push taken
//   pop/dout: read side, pop ignored when empty | empty, full, count: occupancy
module console_fifo #(
    parameter int DEPTH = 8,
    parameter int W     = 8
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      push,
    input  logic [W-1:0]              din,
    output logic                      accept,
    input  logic                      pop,
    output logic [W-1:0]              dout,
    output logic                      empty,
    output logic                      full,
    output logic [$clog2(DEPTH):0]    count
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0] mem [DEPTH];
    logic [AW:0]  wp, rp;
    logic         do_pop;

    // An extra pointer bit tells full from empty when the indices match
    always_comb begin
        empty  = wp == rp;
        full   = (wp[AW] != rp[AW]) && (wp[AW-1:0] == rp[AW-1:0]);
        count  = wp - rp;
        do_pop = pop && !empty;
        accept = push && (!full || do_pop);
        dout   = empty ? '0 : mem[rp[AW-1:0]];
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            wp <= '0;
            rp <= '0;
        end else begin
            if (accept) wp <= wp + 1'b1;
            if (do_pop) rp <= rp + 1'b1;
        end
    end

    always_ff @(posedge clk)
        if (accept) mem[wp[AW-1:0]] <= din;

endmodule

// File: rtl/dmem_responder.sv
// dmem_responder: DMEM slave with doubleword RAM, 64-bit timer/compare irq and console TX FIFO
//   clk, rst (sync, active-low)
//   DMEM_address/WriteData/MemWrite/MemRead in, DMEM_ReadData out (combinational)
//   con_valid/con_data/con_ready: console byte stream | timer_irq: registered mtime >= mtimecmp
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int          MEM_WORDS  = 1024,
    parameter logic [63:0] MMIO_BASE  = 64'h0000_0000_1000_0000,
    parameter int          FIFO_DEPTH = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [63:0] DMEM_address,
    input  logic [63:0] DMEM_WriteData,
    input  logic        DMEM_MemWrite,
    input  logic        DMEM_MemRead,
    output logic [63:0] DMEM_ReadData,
    output logic        con_valid,
    output logic [7:0]  con_data,
    input  logic        con_ready,
    output logic        timer_irq
);
    localparam int AW = $clog2(MEM_WORDS);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    logic [63:0] ram [MEM_WORDS];
    logic [63:0] mtime, mtimecmp, status, rdata;
    logic [AW-1:0] idx;
    logic [CW-1:0] count;
    sel_e  sel;
    logic  push, accept, empty, full, ovf;

    always_comb begin
        idx  = DMEM_address[3 +: AW];
        sel  = DMEM_address < MMIO_BASE ? SEL_RAM : mmio_sel(DMEM_address - MMIO_BASE);
        push = DMEM_MemWrite && sel == SEL_TX;
        status = '0;
        status[EMPTY] = empty;
        status[FULL]  = full;
        status[OVF]   = ovf;
        status[COUNT_LSB +: 8] = 8'(count);
        rdata = sel == SEL_RAM      ? ram[idx] :
                sel == SEL_MTIME    ? mtime    :
                sel == SEL_MTIMECMP ? mtimecmp :
                sel == SEL_TX       ? status   : '0;
        DMEM_ReadData = DMEM_MemRead ? rdata : '0;
        con_valid = !empty;
    end

    // RAM is not reset, but a store coinciding with reset is dropped
    always_ff @(posedge clk)
        if (rst && DMEM_MemWrite && sel == SEL_RAM) ram[idx] <= DMEM_WriteData;

    always_ff @(posedge clk) begin
        if (!rst) begin
            mtime     <= '0;
            mtimecmp  <= '1;
            timer_irq <= 1'b0;
            ovf       <= 1'b0;
        end else begin
            mtime     <= DMEM_MemWrite && sel == SEL_MTIME ? DMEM_WriteData : mtime + 64'd1;
            if (DMEM_MemWrite && sel == SEL_MTIMECMP) mtimecmp <= DMEM_WriteData;
            timer_irq <= mtime >= mtimecmp;
            ovf       <= (ovf && !(DMEM_MemWrite && sel == SEL_CTRL && DMEM_WriteData[CLR_OVF]))
                         || (push && !accept);
        end
    end

    console_fifo #(.DEPTH(FIFO_DEPTH), .W(8)) u_fifo (
        .clk    (clk),
        .rst    (rst),
        .push   (push),
        .din    (DMEM_WriteData[7:0]),
        .accept (accept),
        .pop    (con_ready),
        .dout   (con_data),
        .empty  (empty),
        .full   (full),
        .count  (count)
    );

endmodule

// File: tb/tb_dmem_responder.sv
// tb_dmem_responder: directed self-checking bench for dmem_responder
module tb_dmem_responder;

    localparam logic [63:0] BASE = 64'h1000_0000;
    localparam logic [63:0] A_MT = BASE + 64'h00;
    localparam logic [63:0] A_MC = BASE + 64'h08;
    localparam logic [63:0] A_TX = BASE + 64'h10;
    localparam logic [63:0] A_CT = BASE + 64'h18;
    localparam logic [63:0] PAT  = 64'hDEAD_BEEF_0123_4567;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [63:0] addr = '0, wdata = '0, rdata;
    logic        we = 1'b0, re = 1'b0, con_ready = 1'b0;
    logic        con_valid, timer_irq;
    logic [7:0]  con_data;
    int          checks = 0, fails = 0;

    dmem_responder dut (
        .clk            (clk),
        .rst            (rst),
        .DMEM_address   (addr),
        .DMEM_WriteData (wdata),
        .DMEM_MemWrite  (we),
        .DMEM_MemRead   (re),
        .DMEM_ReadData  (rdata),
        .con_valid      (con_valid),
        .con_data       (con_data),
        .con_ready      (con_ready),
        .timer_irq      (timer_irq)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [63:0] a, input logic [63:0] d);
        addr = a; wdata = d; we = 1'b1;
        tick();
        we = 1'b0;
    endtask

    task automatic check_rd(input string tag, input logic [63:0] a, input logic [63:0] exp);
        addr = a; re = 1'b1;
        #1;
        check(tag, rdata, exp);
        re = 1'b0;
    endtask

    initial begin
        tick();
        tick();
        check("rst_con_valid", 64'(con_valid), 64'd0);
        check("rst_con_data", 64'(con_data), 64'd0);
        check("rst_irq", 64'(timer_irq), 64'd0);
        check("rst_rdata_idle", rdata, 64'd0);
        check_rd("rst_mtime", A_MT, 64'd0);
        check_rd("rst_mtimecmp", A_MC, '1);
        rst = 1'b1;

        wr(64'h40, PAT);
        check_rd("ram_40", 64'h40, PAT);
        check_rd("ram_47", 64'h47, PAT);
        check_rd("ram_alias", 64'h40 + 64'd8192, PAT);

        wr(64'h80, 64'd5);
        addr = 64'h80; wdata = 64'd9; we = 1'b1; re = 1'b1;
        #1;
        check("rw_same_old", rdata, 64'd5);
        tick();
        we = 1'b0; re = 1'b0;
        #1;
        check("rdata_no_read", rdata, 64'd0);
        check_rd("rw_same_new", 64'h80, 64'd9);

        wr(A_MT, 64'd100);
        check_rd("mtime_v", A_MT, 64'd100);
        wr(A_MC, 64'd103);
        check_rd("mtime_v1", A_MT, 64'd101);
        check("irq_101", 64'(timer_irq), 64'd0);
        tick();
        tick();
        check("irq_103", 64'(timer_irq), 64'd0);
        check_rd("mtime_103", A_MT, 64'd103);
        tick();
        check("irq_set", 64'(timer_irq), 64'd1);
        wr(A_MC, '1);
        check("irq_hold", 64'(timer_irq), 64'd1);
        tick();
        check("irq_drop", 64'(timer_irq), 64'd0);

        check("fifo_pre_valid", 64'(con_valid), 64'd0);
        wr(A_TX, 64'h41);
        check("fifo_valid", 64'(con_valid), 64'd1);
        check("fifo_head", 64'(con_data), 64'h41);
        for (int i = 1; i < 9; i++) wr(A_TX, 64'h41 + 64'(i));
        check_rd("status_ovf_full", A_TX, 64'h806);
        check("fifo_head_stable", 64'(con_data), 64'h41);
        con_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            check($sformatf("drain_%0d", i), 64'(con_data), 64'h41 + 64'(i));
            check($sformatf("drain_valid_%0d", i), 64'(con_valid), 64'd1);
            tick();
        end
        con_ready = 1'b0;
        check("drained_valid", 64'(con_valid), 64'd0);
        check("drained_data", 64'(con_data), 64'd0);
        check_rd("status_drained", A_TX, 64'h005);

        wr(A_CT, 64'h4);
        check_rd("ovf_clear", A_TX, 64'h001);
        check_rd("ctrl_read", A_CT, 64'd0);
        for (int i = 0; i < 8; i++) wr(A_TX, 64'h50 + 64'(i));
        check_rd("status_full", A_TX, 64'h802);
        addr = A_TX; wdata = 64'h58; we = 1'b1; con_ready = 1'b1;
        tick();
        we = 1'b0; con_ready = 1'b0;
        check_rd("push_pop_full", A_TX, 64'h802);
        check("push_pop_head", 64'(con_data), 64'h51);

        wr(BASE + 64'h20, 64'd77);
        check_rd("unmapped", BASE + 64'h20, 64'd0);

        con_ready = 1'b1;
        repeat (5) tick();
        con_ready = 1'b0;
        check("three_head", 64'(con_data), 64'h56);
        check_rd("three_status", A_TX, 64'h300);
        wr(A_MT, 64'd500);
        check_rd("mtime_500", A_MT, 64'd500);
        rst = 1'b0; addr = 64'h40; wdata = 64'd0; we = 1'b1;
        tick();
        we = 1'b0; rst = 1'b1;
        check("mid_rst_valid", 64'(con_valid), 64'd0);
        check("mid_rst_data", 64'(con_data), 64'd0);
        check("mid_rst_irq", 64'(timer_irq), 64'd0);
        check_rd("mid_rst_status", A_TX, 64'h001);
        check_rd("mid_rst_mtime", A_MT, 64'd0);
        check_rd("rst_write_blocked", 64'h40, PAT);
        tick();
        check_rd("mtime_restart", A_MT, 64'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
